// File: rtl/arf_pkg.sv
// Shared widths and FSM state encoding for the ARF frame adapter.
package arf_pkg;
    localparam int ARF_DATA_W = 16;
    localparam int ARF_NUM_IN = 8;
    localparam int ARF_RES_W  = 64;

    typedef enum logic [1:0] {LOAD, WAIT, SEND0, SEND1} arf_io_state_t;
endpackage

// File: rtl/arf_frame_io.sv
// Frame adapter around the ARF variance datapath: assembles 8-sample frames,
// waits a settle latency, captures both results and streams them as two beats.
module arf_frame_io
    import arf_pkg::*;
#(
    parameter int DATA_W = ARF_DATA_W,
    parameter int NUM_IN = ARF_NUM_IN,
    parameter int RES_W  = ARF_RES_W,
    parameter int LAT    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic [NUM_IN*DATA_W-1:0] arf_in,
    input  logic [RES_W-1:0]         arf_res0,
    input  logic [RES_W-1:0]         arf_res1,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RES_W-1:0]         m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    arf_io_state_t     state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [RES_W-1:0]  r0_reg, r1_reg;
    logic [15:0]       frame_cnt_reg;
    logic              accept, last_slot, capture, done;

    assign last_slot = (idx_reg == IDX_W'(NUM_IN - 1));
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= LOAD;
        else        state_reg <= state_next;
    end

    // Outputs decode from state and registered results only, so m_ready never reaches m_valid.
    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        busy       = 1'b1;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    accept = 1'b1;
                    if (last_slot) state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = SEND0;
                end
            end
            SEND0: begin
                m_valid = 1'b1;
                m_data  = r0_reg;
                if (m_ready) state_next = SEND1;
            end
            SEND1: begin
                m_valid = 1'b1;
                m_data  = r1_reg;
                m_last  = 1'b1;
                if (m_ready) begin
                    done       = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg       <= '0;
            cnt_reg       <= '0;
            r0_reg        <= '0;
            r1_reg        <= '0;
            frame_cnt_reg <= '0;
        end else begin
            if (accept) idx_reg <= last_slot ? '0 : idx_reg + 1'b1;
            if (accept && last_slot)
                cnt_reg <= CNT_W'(LAT);
            else if (state_reg == WAIT && cnt_reg != '0)
                cnt_reg <= cnt_reg - 1'b1;
            if (capture) begin
                r0_reg <= arf_res0;
                r1_reg <= arf_res1;
            end
            if (done) frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    // Slots are never cleared between frames; a new frame simply overwrites them in order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    slot_reg <= '0;
                else if (accept && idx_reg == IDX_W'(gi))
                    slot_reg <= s_data;
            end
            assign arf_in[gi*DATA_W +: DATA_W] = slot_reg;
        end
    endgenerate
endmodule
